// File: rtl/decimal_entry_pkg.sv
// Shared key codes and FSM state type for the keypad decimal entry block.
package decimal_entry_pkg;

   // Codes 0x0..0x9 are digits; 0xD and 0xF are deliberately unused.
   localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
   localparam logic [3:0] KEY_NEG       = 4'hA;
   localparam logic [3:0] KEY_BKSP      = 4'hB;
   localparam logic [3:0] KEY_CLR       = 4'hC;
   localparam logic [3:0] KEY_ENTER     = 4'hE;

   typedef enum logic {
      ENTRY   = 1'b0,
      CONVERT = 1'b1
   } state_t;

endpackage

// File: rtl/bcd_mul10_add.sv
// Combinational accumulate step: result = acc*10 + digit, built from shifts.
module bcd_mul10_add (
   input  logic [31:0] acc,
   input  logic [3:0]  digit,
   output logic [31:0] result
);

   // acc*10 = acc*8 + acc*2; the magnitude bound keeps this from overflowing.
   assign result = (acc << 3) + (acc << 1) + {28'd0, digit};

endmodule

// File: rtl/decimal_entry_to_binary.sv
// Keypad decimal entry: collects BCD digits and a sign, then converts the
// entry MSD-first into a 32-bit two's-complement value on enter.
//
// Handshake: a key is consumed on a rising edge where key_valid && ready;
// a key strobed while ready is low is dropped, never queued.
module decimal_entry_to_binary
   import decimal_entry_pkg::*;
#(
   parameter int NUM_DIGITS = 5
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              key_valid,
   input  logic [3:0]                        key_code,
   output logic                              ready,
   output logic [4*NUM_DIGITS-1:0]           bcd_digits,
   output logic                              neg,
   output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
   output logic [31:0]                       value,
   output logic                              value_valid,
   output state_t                            state_dbg
);

   localparam int DW = 4 * NUM_DIGITS;
   localparam int CW = $clog2(NUM_DIGITS + 1);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   state_t          state;
   logic [DW-1:0]   work_digits;
   logic            work_neg;
   logic [31:0]     acc;
   logic [IW-1:0]   idx;

   logic [DW-1:0]   work_shifted;
   logic [3:0]      cur_digit;
   logic [31:0]     acc_next;

   assign ready     = (state == ENTRY);
   assign state_dbg = state;

   // The digit being folded in is the one at position idx of the snapshot.
   assign work_shifted = work_digits >> {idx, 2'b00};
   assign cur_digit    = work_shifted[3:0];

   bcd_mul10_add u_mul10_add (
      .acc    (acc),
      .digit  (cur_digit),
      .result (acc_next)
   );

   // Entry editing, conversion sequencing and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ENTRY;
         bcd_digits  <= '0;
         digit_count <= '0;
         neg         <= 1'b0;
         work_digits <= '0;
         work_neg    <= 1'b0;
         acc         <= '0;
         idx         <= '0;
         value       <= '0;
         value_valid <= 1'b0;
      end else begin
         value_valid <= 1'b0;
         case (state)
            ENTRY: begin
               if (key_valid) begin
                  if (key_code <= KEY_DIGIT_MAX) begin
                     // A full entry silently ignores further digits.
                     if (digit_count < CW'(NUM_DIGITS)) begin
                        bcd_digits  <= (bcd_digits << 4) | DW'(key_code);
                        digit_count <= digit_count + 1'b1;
                     end
                  end else if (key_code == KEY_NEG) begin
                     neg <= ~neg;
                  end else if (key_code == KEY_BKSP) begin
                     if (digit_count != '0) begin
                        bcd_digits  <= bcd_digits >> 4;
                        digit_count <= digit_count - 1'b1;
                     end
                  end else if (key_code == KEY_CLR) begin
                     bcd_digits  <= '0;
                     digit_count <= '0;
                     neg         <= 1'b0;
                  end else if (key_code == KEY_ENTER) begin
                     // Snapshot then clear, so the display is blank while converting.
                     work_digits <= bcd_digits;
                     work_neg    <= neg;
                     acc         <= '0;
                     idx         <= IW'(NUM_DIGITS - 1);
                     bcd_digits  <= '0;
                     digit_count <= '0;
                     neg         <= 1'b0;
                     state       <= CONVERT;
                  end
               end
            end
            CONVERT: begin
               // Always runs all NUM_DIGITS steps, even for an empty entry.
               acc <= acc_next;
               if (idx == '0) begin
                  value       <= work_neg ? (~acc_next + 32'd1) : acc_next;
                  value_valid <= 1'b1;
                  state       <= ENTRY;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            default: state <= ENTRY;
         endcase
      end
   end

endmodule

// File: tb/tb_decimal_entry_to_binary.sv
// Bench for decimal_entry_to_binary: directed key sequences plus random keys,
// checked against an integer-arithmetic model of the entry and a scoreboard
// of expected converted values.
module tb_decimal_entry_to_binary;
  import decimal_entry_pkg::*;

  localparam int N  = 5;
  localparam int CW = $clog2(N + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic key_valid;
  logic [3:0] key_code;
  logic ready;
  logic [4*N-1:0] bcd_digits;
  logic neg;
  logic [CW-1:0] digit_count;
  logic [31:0] value;
  logic value_valid;
  state_t state_dbg;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  decimal_entry_to_binary #(.NUM_DIGITS(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .ready       (ready),
    .bcd_digits  (bcd_digits),
    .neg         (neg),
    .digit_count (digit_count),
    .value       (value),
    .value_valid (value_valid),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  int unsigned exp_cyc_q[$];

  // Reference entry model: magnitude as a plain integer, digit count, sign.
  int m_mag = 0;
  int m_cnt = 0;
  bit m_neg = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4*N-1:0] exp_bcd(input int mag);
    int m;
    logic [4*N-1:0] r;
    m = mag;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Called at a negedge, just before the edge that samples key k.
  task automatic model_key(input logic [3:0] k);
    if (k <= 4'd9) begin
      if (m_cnt < N) begin
        m_mag = m_mag * 10 + int'(k);
        m_cnt++;
      end
    end else if (k == 4'hA) begin
      m_neg = !m_neg;
    end else if (k == 4'hB) begin
      if (m_cnt > 0) begin
        m_mag = m_mag / 10;
        m_cnt--;
      end
    end else if (k == 4'hC) begin
      m_mag = 0; m_cnt = 0; m_neg = 1'b0;
    end else if (k == 4'hE) begin
      exp_q.push_back(m_neg ? 32'(-m_mag) : 32'(m_mag));
      // Sampling edge is cyc+1; result visible after edge cyc+1+N.
      exp_cyc_q.push_back(cyc + 1 + N);
      m_mag = 0; m_cnt = 0; m_neg = 1'b0;
    end
  endtask

  task automatic check_entry();
    check("bcd_digits", 32'(bcd_digits), 32'(exp_bcd(m_mag)));
    check("digit_count", 32'(digit_count), 32'(m_cnt));
    check("neg", 32'(neg), 32'(m_neg));
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: ready %0b expected 1 within 40 cycles", ready);
    end
  endtask

  task automatic send_key(input logic [3:0] k);
    wait_ready();
    key_code  = k;
    key_valid = 1'b1;
    model_key(k);
    @(posedge clk);
    #1 key_valid = 1'b0;
    @(negedge clk);
    check_entry();
    if (k == 4'hE) check("ready_after_enter", 32'(ready), 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    int unsigned ec;
    if (!rst && value_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_value_valid: value %0h with no conversion pending", value);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("value", value, e);
        check("valid_cycle", 32'(cyc), 32'(ec));
        check("ready_with_valid", 32'(ready), 32'd1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    int n;
    rst = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_value", value, 32'd0);
    check("reset_value_valid", 32'(value_valid), 32'd0);
    check_entry();

    // 12345 -> 0x3039
    send_key(4'h1); send_key(4'h2); send_key(4'h3); send_key(4'h4); send_key(4'h5);
    send_key(4'hE);
    // -99999
    send_key(4'hA);
    for (int i = 0; i < 5; i++) send_key(4'h9);
    send_key(4'hE);
    // sixth digit ignored
    for (int i = 1; i <= 6; i++) send_key(4'(i));
    send_key(4'hE);
    // 4,2,bksp,7 -> 47
    send_key(4'h4); send_key(4'h2); send_key(4'hB); send_key(4'h7); send_key(4'hE);
    // sign on empty entry -> 0
    send_key(4'hA); send_key(4'hE);
    // backspace on empty entry, leading zeros, ignored codes, clear
    send_key(4'hB);
    send_key(4'h0); send_key(4'h0); send_key(4'h3); send_key(4'hD); send_key(4'hF);
    send_key(4'hA); send_key(4'hC);
    send_key(4'h6); send_key(4'hA); send_key(4'hE);

    // key strobed during conversion is dropped
    send_key(4'h8); send_key(4'hE);
    key_code = 4'h3;
    key_valid = 1'b1;
    @(posedge clk);
    #1 key_valid = 1'b0;
    @(negedge clk);
    check_entry();
    wait_ready();
    @(negedge clk);
    check("value_holds", value, 32'd8);
    check_entry();

    // reset two cycles into conversion aborts it
    send_key(4'h7); send_key(4'hE);
    @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_value", value, 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_value_valid", 32'(value_valid), 32'd0);
    check_entry();
    repeat (N + 2) @(negedge clk);

    // random keys
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      send_key(4'($urandom_range(0, 9)));
      else if (r < 63) send_key(4'hA);
      else if (r < 71) send_key(4'hB);
      else if (r < 75) send_key(4'hC);
      else if (r < 88) send_key(4'hE);
      else             send_key(($urandom_range(0, 1) == 0) ? 4'hD : 4'hF);
    end

    // drain outstanding conversions
    n = 0;
    while (exp_q.size() != 0 && n < 4 * N) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("pending_conversions", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
